cw310_crypt_sequencer: RTL and testbench
========================================

Name: cw310_crypt_sequencer

Overview:
Sequences the crypto core on the crypto_clk domain. It sits between the start sources and the core's start/ready/done handshake. The start sources are the USB-register go pulse after CDC and the synchronized external trigger. The block arbitrates these sources, runs batches of N back-to-back operations, measures per-operation latency and aborts hung operations on a timeout.

Parameters:
pBATCH_WIDTH, 16, width of batch count and remaining-run counter
pLAT_WIDTH, 32, width of the latency counter (saturating)
pTIMEOUT, 100000, max crypto_clk cycles in RUN before abort (1..2^pLAT_WIDTH-1)

Ports:
crypto_clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
I_go_reg  in  1  one-cycle start request from register CDC
I_go_ext  in  1  external trigger level, already 2-flop synchronized
I_ext_en  in  1  1 = rising edges of I_go_ext are accepted
I_batch_count  in  pBATCH_WIDTH  runs per accepted request; 0 treated as 1
I_ready  in  1  core ready
I_done  in  1  core done; high for 1 or more cycles, rising edge used
I_clear  in  1  one-cycle clear of sticky flags
O_start  out  1  one-cycle start to core
O_busy  out  1  high in any state except IDLE
O_runs_done  out  pBATCH_WIDTH  runs completed in current/last batch
O_last_latency  out  pLAT_WIDTH  cycles from O_start to done edge, last run
O_timeout  out  1  sticky, run aborted by timeout
O_dropped  out  1  sticky, request lost because pending slot full

Behaviour:
- Reset (async assert, sync release to crypto_clk): state IDLE. All outputs 0. Pending flags, edge-detect register and counters are 0.
- Ext edge: ext_rise = I_go_ext & ~ext_q & I_ext_en. ext_q is registered every cycle, including while I_ext_en=0. Enabling the external source while the trigger is high therefore does not fire.
- Request sources: reg request = I_go_reg. Ext request = ext_rise.
- Pending slot: one per source.
  - A request arriving while a slot of that source is already set, or arriving while busy with that slot set, sets O_dropped.
  - Requests arriving while busy set the slot if it is clear.
- Arbitration in IDLE: register (pending or live) has priority over ext. If both are present, reg is served and ext stays pending. It is served after the batch, with no idle cycle lost.
- Accept: load remaining = (I_batch_count==0) ? 1 : I_batch_count. Clear O_runs_done. Clear the served pending flag. Go to WAIT_RDY.
- WAIT_RDY: wait for I_ready=1, then go to START.
- START: O_start=1 for exactly this cycle. Clear the latency counter to 0. Go to RUN.
- RUN:
  - The counter increments each cycle, saturating at all-ones.
  - On done rising edge (I_done & ~done_q):
    - O_last_latency = counter+1, so a done edge in the cycle right after O_start gives 1.
    - O_runs_done++ and remaining--.
    - If remaining becomes 0, go to IDLE. Otherwise go to WAIT_RDY.
  - If the counter reaches pTIMEOUT-1 with no done edge: set O_timeout, discard the remaining runs, go to IDLE. O_last_latency is unchanged.
- done_q is registered in all states. A done that is already high on entry to RUN is not an edge.
- I_done edges outside RUN are ignored.
- I_clear clears O_timeout and O_dropped. If a set event occurs in the same cycle, the set wins.
- Pending requests are evaluated in IDLE on the cycle after the batch ends. Latency from request to O_start with I_ready=1 is 3 cycles: accept, WAIT_RDY, START.

Optional Feature:
Macro CW310_CRYPT_SEQ_TRIG_OUT_EN.
- Defined: adds output port O_trig_out (1 bit, reset 0). It is registered high the cycle after O_start and low the cycle after the done edge or timeout. This gives a scope trigger aligned to the core's active window.
- Undefined: port and logic absent. Behaviour otherwise identical.

Test Plan:
- Reset mid-RUN (assert reset_n=0 at RUN cycle 5) -> all outputs 0 immediately, IDLE. A later I_done edge causes no change.
- I_go_reg pulse, batch=0, I_ready=1, core done 10 cycles after start -> one O_start 3 cycles after the pulse. O_last_latency=10, O_runs_done=1, O_busy low afterwards.
- batch=3, I_ready toggled low 4 cycles between runs -> exactly 3 O_start pulses, each waiting for ready. O_runs_done=3.
- I_go_reg and ext rise in the same cycle, I_ext_en=1 -> reg batch runs first, then ext batch immediately after. A second ext rise during the first batch sets O_dropped=1, and I_clear returns it to 0.
- pTIMEOUT=50, I_done never asserted -> abort after 50 RUN cycles. O_timeout=1, remaining runs of batch=4 discarded, O_runs_done=0.
- I_go_ext high while I_ext_en=0, then I_ext_en set -> no start. The next low→high of I_go_ext triggers exactly one batch.

Source files
------------

// File: rtl/cw310_crypt_sequencer.sv
// Crypto-core start sequencer on crypto_clk: arbitrates register/external start
// requests, runs batches, measures per-run latency and aborts hung runs.
// Optional scope-trigger output O_trig_out under CW310_CRYPT_SEQ_TRIG_OUT_EN.
module cw310_crypt_sequencer #(
  parameter int unsigned pBATCH_WIDTH = 16,
  parameter int unsigned pLAT_WIDTH   = 32,
  parameter int unsigned pTIMEOUT     = 100000
) (
  input  logic                    crypto_clk,
  input  logic                    reset_n,
  input  logic                    I_go_reg,
  input  logic                    I_go_ext,
  input  logic                    I_ext_en,
  input  logic [pBATCH_WIDTH-1:0] I_batch_count,
  input  logic                    I_ready,
  input  logic                    I_done,
  input  logic                    I_clear,
  output logic                    O_start,
  output logic                    O_busy,
  output logic [pBATCH_WIDTH-1:0] O_runs_done,
  output logic [pLAT_WIDTH-1:0]   O_last_latency,
  output logic                    O_timeout,
  output logic                    O_dropped
`ifdef CW310_CRYPT_SEQ_TRIG_OUT_EN
  ,
  output logic                    O_trig_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_START,
    ST_RUN
  } state_e;

  localparam logic [pLAT_WIDTH-1:0]   TIMEOUT_LAST = pLAT_WIDTH'(pTIMEOUT - 1);
  localparam logic [pBATCH_WIDTH-1:0] BATCH_ONE    = pBATCH_WIDTH'(1);

  state_e                  state_q, state_d;
  logic                    go_ext_q, done_q;
  logic                    pend_reg_q, pend_reg_d;
  logic                    pend_ext_q, pend_ext_d;
  logic [pBATCH_WIDTH-1:0] remaining_q, remaining_d;
  logic [pBATCH_WIDTH-1:0] runs_done_q, runs_done_d;
  logic [pLAT_WIDTH-1:0]   lat_cnt_q, lat_cnt_d;
  logic [pLAT_WIDTH-1:0]   last_lat_q, last_lat_d;
  logic                    timeout_q, timeout_d;
  logic                    dropped_q, dropped_d;

  logic                    ext_rise, done_rise, idle;
  logic                    serve_reg, serve_ext, drop_evt, timeout_hit;
  logic [pLAT_WIDTH-1:0]   lat_inc;

  always_comb begin
    ext_rise    = I_go_ext & ~go_ext_q & I_ext_en;
    done_rise   = I_done & ~done_q;
    idle        = (state_q == ST_IDLE);
    serve_reg   = idle & (pend_reg_q | I_go_reg);
    serve_ext   = idle & ~serve_reg & (pend_ext_q | ext_rise);
    // A request finding its slot already occupied is lost, even in the IDLE
    // cycle that is about to serve that slot.
    drop_evt    = (I_go_reg & pend_reg_q) | (ext_rise & pend_ext_q);
    lat_inc     = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + pLAT_WIDTH'(1);
    timeout_hit = (state_q == ST_RUN) & ~done_rise & (lat_cnt_q == TIMEOUT_LAST);
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    runs_done_d = runs_done_q;
    lat_cnt_d   = lat_cnt_q;
    last_lat_d  = last_lat_q;
    pend_reg_d  = serve_reg ? 1'b0 : (pend_reg_q | I_go_reg);
    pend_ext_d  = serve_ext ? 1'b0 : (pend_ext_q | ext_rise);
    timeout_d   = timeout_hit ? 1'b1 : (I_clear ? 1'b0 : timeout_q);
    dropped_d   = drop_evt    ? 1'b1 : (I_clear ? 1'b0 : dropped_q);

    case (state_q)
      ST_IDLE: begin
        if (serve_reg || serve_ext) begin
          remaining_d = (I_batch_count == '0) ? BATCH_ONE : I_batch_count;
          runs_done_d = '0;
          state_d     = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (I_ready) state_d = ST_START;
      end
      ST_START: begin
        lat_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        lat_cnt_d = lat_inc;
        if (done_rise) begin
          last_lat_d  = lat_inc;
          runs_done_d = runs_done_q + BATCH_ONE;
          remaining_d = remaining_q - BATCH_ONE;
          state_d     = (remaining_q == BATCH_ONE) ? ST_IDLE : ST_WAIT_RDY;
        end else if (timeout_hit) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      go_ext_q    <= 1'b0;
      done_q      <= 1'b0;
      pend_reg_q  <= 1'b0;
      pend_ext_q  <= 1'b0;
      remaining_q <= '0;
      runs_done_q <= '0;
      lat_cnt_q   <= '0;
      last_lat_q  <= '0;
      timeout_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_ext_q    <= I_go_ext;
      done_q      <= I_done;
      pend_reg_q  <= pend_reg_d;
      pend_ext_q  <= pend_ext_d;
      remaining_q <= remaining_d;
      runs_done_q <= runs_done_d;
      lat_cnt_q   <= lat_cnt_d;
      last_lat_q  <= last_lat_d;
      timeout_q   <= timeout_d;
      dropped_q   <= dropped_d;
    end
  end

  assign O_start        = (state_q == ST_START);
  assign O_busy         = (state_q != ST_IDLE);
  assign O_runs_done    = runs_done_q;
  assign O_last_latency = last_lat_q;
  assign O_timeout      = timeout_q;
  assign O_dropped      = dropped_q;

`ifdef CW310_CRYPT_SEQ_TRIG_OUT_EN
  logic trig_q, trig_d;

  always_comb begin
    trig_d = trig_q;
    if (state_q == ST_START) begin
      trig_d = 1'b1;
    end else if ((state_q == ST_RUN) && (done_rise || timeout_hit)) begin
      trig_d = 1'b0;
    end
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) trig_q <= 1'b0;
    else          trig_q <= trig_d;
  end

  assign O_trig_out = trig_q;
`endif

endmodule

// File: tb/tb_cw310_crypt_sequencer.sv
// Directed + randomized bench for cw310_crypt_sequencer; the bench acts as the
// crypto core and predicts starts, latencies and run counts from batch rules.
module tb_cw310_crypt_sequencer;

  localparam int unsigned BW = 16;
  localparam int unsigned LW = 32;
  localparam int unsigned TO = 50;

  logic          crypto_clk;
  logic          reset_n;
  logic          I_go_reg, I_go_ext, I_ext_en, I_ready, I_done, I_clear;
  logic [BW-1:0] I_batch_count;
  logic          O_start, O_busy, O_timeout, O_dropped;
  logic [BW-1:0] O_runs_done;
  logic [LW-1:0] O_last_latency;
`ifdef CW310_CRYPT_SEQ_TRIG_OUT_EN
  logic          O_trig_out;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned last_d   = 0;

  cw310_crypt_sequencer #(
    .pBATCH_WIDTH(BW),
    .pLAT_WIDTH  (LW),
    .pTIMEOUT    (TO)
  ) dut (
    .crypto_clk    (crypto_clk),
    .reset_n       (reset_n),
    .I_go_reg      (I_go_reg),
    .I_go_ext      (I_go_ext),
    .I_ext_en      (I_ext_en),
    .I_batch_count (I_batch_count),
    .I_ready       (I_ready),
    .I_done        (I_done),
    .I_clear       (I_clear),
    .O_start       (O_start),
    .O_busy        (O_busy),
    .O_runs_done   (O_runs_done),
    .O_last_latency(O_last_latency),
    .O_timeout     (O_timeout),
    .O_dropped     (O_dropped)
`ifdef CW310_CRYPT_SEQ_TRIG_OUT_EN
    ,
    .O_trig_out    (O_trig_out)
`endif
  );

  initial begin
    crypto_clk = 1'b0;
    forever #5 crypto_clk = ~crypto_clk;
  end

  task automatic tick();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chkv(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  function automatic int unsigned runs_for(input int unsigned bc);
    return (bc == 0) ? 1 : bc;
  endfunction

  // Entered in the cycle after accept (WAIT_RDY) with I_ready=1; plays the core.
  task automatic do_batch(input int unsigned n_runs, input int unsigned gap_lo,
                          input int unsigned gap_hi, input int unsigned d_lo,
                          input int unsigned d_hi);
    for (int unsigned k = 0; k < n_runs; k++) begin
      int unsigned gap;
      int unsigned d;
      gap = (k == 0) ? 0 : $urandom_range(gap_hi, gap_lo);
      if (gap > 0) begin
        I_ready = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
          tick();
          chk1("no_start_wo_ready", O_start, 1'b0);
          chk1("busy_waiting_ready", O_busy, 1'b1);
        end
        I_ready = 1'b1;
      end
      tick();
      chk1("start_pulse", O_start, 1'b1);
      d = $urandom_range(d_hi, d_lo);
      for (int unsigned c = 0; c < d; c++) begin
        tick();
        chk1("start_one_cycle", O_start, 1'b0);
      end
      I_done = 1'b1;
      tick();
      I_done = 1'b0;
      last_d = d;
      chkv("last_latency", 64'(O_last_latency), 64'(d));
      chkv("runs_done", 64'(O_runs_done), 64'(k + 1));
      chk1("busy_after_done", O_busy, (k + 1 < n_runs));
    end
  endtask

  task automatic idle_check(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      chk1("stays_idle", O_busy, 1'b0);
      chk1("no_spurious_start", O_start, 1'b0);
    end
  endtask

  task automatic reg_pulse(input int unsigned bc);
    I_batch_count = BW'(bc);
    I_go_reg = 1'b1;
    tick();
    I_go_reg = 1'b0;
    chk1("accept_busy", O_busy, 1'b1);
    chk1("accept_no_start", O_start, 1'b0);
  endtask

  initial begin
    int unsigned bc1, bc2;
    reset_n = 1'b0;
    I_go_reg = 1'b0; I_go_ext = 1'b0; I_ext_en = 1'b0;
    I_ready = 1'b1; I_done = 1'b0; I_clear = 1'b0;
    I_batch_count = '0;
    #3;
    chk1("rst_start", O_start, 1'b0);
    chk1("rst_busy", O_busy, 1'b0);
    chkv("rst_runs", 64'(O_runs_done), 64'd0);
    chkv("rst_lat", 64'(O_last_latency), 64'd0);
    chk1("rst_timeout", O_timeout, 1'b0);
    chk1("rst_dropped", O_dropped, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single run, batch=0 treated as one, fixed 10-cycle core.
    reg_pulse(0);
    do_batch(1, 0, 0, 10, 10);
    idle_check(3);

    // Batch of 3 with ready dropped 4 cycles between runs.
    reg_pulse(3);
    do_batch(3, 4, 4, 1, 20);
    idle_check(2);

    // Simultaneous reg + ext: reg first, ext back-to-back, second ext dropped.
    I_ext_en = 1'b1;
    bc1 = $urandom_range(3, 1);
    bc2 = $urandom_range(2, 0);
    I_batch_count = BW'(bc1);
    I_go_reg = 1'b1; I_go_ext = 1'b1;
    tick();
    I_go_reg = 1'b0; I_go_ext = 1'b0; I_ready = 1'b0;
    chk1("dual_accept_busy", O_busy, 1'b1);
    tick();
    I_go_ext = 1'b1;
    tick();
    chk1("dropped_set", O_dropped, 1'b1);
    chk1("dropped_no_start", O_start, 1'b0);
    I_clear = 1'b1;
    tick();
    I_clear = 1'b0;
    chk1("dropped_cleared", O_dropped, 1'b0);
    I_ready = 1'b1;
    I_batch_count = BW'(bc2);
    do_batch(runs_for(bc1), 0, 3, 1, 20);
    chk1("idle_between_batches", O_busy, 1'b0);
    tick();
    chk1("ext_pending_accept", O_busy, 1'b1);
    chkv("ext_runs_cleared", 64'(O_runs_done), 64'd0);
    do_batch(runs_for(bc2), 0, 3, 1, 20);
    idle_check(5);
    I_go_ext = 1'b0;
    I_ext_en = 1'b0;
    tick();

    // Timeout: core never finishes, remaining runs of batch=4 discarded.
    reg_pulse(4);
    tick();
    chk1("to_start", O_start, 1'b1);
    for (int unsigned j = 1; j <= TO; j++) begin
      tick();
      chk1("to_busy_in_run", O_busy, 1'b1);
      chk1("to_not_yet", O_timeout, 1'b0);
    end
    tick();
    chk1("to_idle", O_busy, 1'b0);
    chk1("to_flag", O_timeout, 1'b1);
    chkv("to_runs_done", 64'(O_runs_done), 64'd0);
    chkv("to_lat_kept", 64'(O_last_latency), 64'(last_d));
    idle_check(6);
    I_clear = 1'b1;
    tick();
    I_clear = 1'b0;
    chk1("to_cleared", O_timeout, 1'b0);

    // Enabling ext while trigger already high must not fire.
    I_go_ext = 1'b1;
    idle_check(3);
    I_ext_en = 1'b1;
    idle_check(3);
    I_go_ext = 1'b0;
    idle_check(1);
    bc1 = $urandom_range(3, 0);
    I_batch_count = BW'(bc1);
    I_go_ext = 1'b1;
    tick();
    chk1("ext_rise_accept", O_busy, 1'b1);
    do_batch(runs_for(bc1), 0, 2, 1, 20);
    idle_check(4);
    I_go_ext = 1'b0;
    I_ext_en = 1'b0;

    // Randomized register batches.
    for (int unsigned it = 0; it < 6; it++) begin
      bc1 = $urandom_range(4, 0);
      reg_pulse(bc1);
      do_batch(runs_for(bc1), 0, 4, 1, 20);
      idle_check(1);
    end

    // Reset asserted in RUN cycle 5; a later done edge changes nothing.
    reg_pulse(2);
    tick();
    chk1("rr_start", O_start, 1'b1);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk1("rr_busy", O_busy, 1'b0);
    chk1("rr_start_low", O_start, 1'b0);
    chkv("rr_runs", 64'(O_runs_done), 64'd0);
    chkv("rr_lat", 64'(O_last_latency), 64'd0);
    chk1("rr_timeout", O_timeout, 1'b0);
    chk1("rr_dropped", O_dropped, 1'b0);
    tick();
    reset_n = 1'b1;
    I_done = 1'b1;
    tick();
    I_done = 1'b0;
    tick();
    chk1("rr_done_ignored_busy", O_busy, 1'b0);
    chkv("rr_done_ignored_lat", 64'(O_last_latency), 64'd0);
    chkv("rr_done_ignored_runs", 64'(O_runs_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
